// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
// input_conditioner : sync + debounce of cabinet buttons, queued coin pulses
// Revision 1.0
// ============================================================================
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES   = 100000,
    parameter int COIN_PULSE_CYCLES = 500000,
    parameter int COIN_GAP_CYCLES   = 500000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_coinl,
    input  logic       btn_coinr,
    input  logic       btn_start1,
    input  logic       btn_start2,
    input  logic       btn_test,
    output logic       COINL,
    output logic       COINR,
    output logic       STARTJMP1,
    output logic       STARTJMP2,
    output logic       SELFTEST,
    output logic [1:0] coin_pending_l,
    output logic [1:0] coin_pending_r
);

    localparam int c_n_in     = 5;
    localparam int c_deb_w    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_coin_max = (COIN_PULSE_CYCLES > COIN_GAP_CYCLES) ? COIN_PULSE_CYCLES
                                                                      : COIN_GAP_CYCLES;
    localparam int c_coin_w   = (c_coin_max > 1) ? $clog2(c_coin_max) : 1;

    localparam logic [c_deb_w-1:0]  c_deb_last  = c_deb_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_coin_w-1:0] c_pulse_ld  = c_coin_w'(COIN_PULSE_CYCLES - 1);
    localparam logic [c_coin_w-1:0] c_gap_ld    = c_coin_w'(COIN_GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } coin_state_t;

    logic [c_n_in-1:0] w_raw;
    logic [c_n_in-1:0] w_deb;
    logic [1:0]        w_coin;
    logic [1:0]        w_pend [2];
    logic [2:0]        lvl_q;

    // Bit order: coinl, coinr, start1, start2, test
    assign w_raw = {btn_test, btn_start2, btn_start1, btn_coinr, btn_coinl};

    for (genvar gi = 0; gi < c_n_in; gi++) begin : g_deb
        logic [1:0]         sync_q;
        logic               deb_q;
        logic [c_deb_w-1:0] cnt_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sync_q <= 2'b00;
                deb_q  <= 1'b0;
                cnt_q  <= '0;
            end else begin
                sync_q <= {sync_q[0], w_raw[gi]};
                if (sync_q[1] == deb_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == c_deb_last) begin
                    deb_q <= sync_q[1];
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end

        assign w_deb[gi] = deb_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lvl_q <= 3'b111;
        end else begin
            lvl_q <= ~w_deb[4:2];
        end
    end

    for (genvar gs = 0; gs < 2; gs++) begin : g_coin
        coin_state_t         state_q;
        logic [c_coin_w-1:0] cnt_q;
        logic                prev_q;
        logic                coin_q;
        logic [1:0]          pend_q;
        logic [1:0]          pend_d;
        logic                w_rise;
        logic                w_consume;
        logic [2:0]          w_pend_sum;

        assign w_rise     = w_deb[gs] & ~prev_q;
        assign w_consume  = (pend_q != 2'd0) &&
                            ((state_q == ST_IDLE) || ((state_q == ST_GAP) && (cnt_q == '0)));
        // A consume implies pend_q >= 1, so the sum never underflows; a full
        // queue with a coincident consume still accepts the new edge.
        assign w_pend_sum = {1'b0, pend_q} + {2'b00, w_rise} - {2'b00, w_consume};
        assign pend_d     = (w_pend_sum > 3'd3) ? 2'd3 : w_pend_sum[1:0];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                prev_q  <= 1'b0;
                coin_q  <= 1'b1;
                pend_q  <= 2'd0;
            end else begin
                prev_q <= w_deb[gs];
                pend_q <= pend_d;
                case (state_q)
                    ST_IDLE: begin
                        if (w_consume) begin
                            state_q <= ST_PULSE;
                            cnt_q   <= c_pulse_ld;
                            coin_q  <= 1'b0;
                        end
                    end
                    ST_PULSE: begin
                        if (cnt_q == '0) begin
                            state_q <= ST_GAP;
                            cnt_q   <= c_gap_ld;
                            coin_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    ST_GAP: begin
                        if (cnt_q == '0) begin
                            if (w_consume) begin
                                state_q <= ST_PULSE;
                                cnt_q   <= c_pulse_ld;
                                coin_q  <= 1'b0;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        coin_q  <= 1'b1;
                    end
                endcase
            end
        end

        assign w_coin[gs] = coin_q;
        assign w_pend[gs] = pend_q;
    end

    assign COINL          = w_coin[0];
    assign COINR          = w_coin[1];
    assign STARTJMP1      = lvl_q[0];
    assign STARTJMP2      = lvl_q[1];
    assign SELFTEST       = lvl_q[2];
    assign coin_pending_l = w_pend[0];
    assign coin_pending_r = w_pend[1];

endmodule
`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
// ============================================================================
// tb_input_conditioner : directed self-checking bench for input_conditioner
// Revision 1.0
// ============================================================================
module tb_input_conditioner;

    localparam int DEB = 4;
    localparam int PUL = 6;
    localparam int GAP = 5;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       btn_coinl, btn_coinr, btn_start1, btn_start2, btn_test;
    logic       COINL, COINR, STARTJMP1, STARTJMP2, SELFTEST;
    logic [1:0] coin_pending_l, coin_pending_r;

    int checks = 0;
    int errors = 0;

    // Per-scenario tables: tap start slots, expected pulse start slots,
    // and (slot, value) pairs for pending-count spot checks.
    int tap_q[$];
    int start_q[$];
    int pslot_q[$];
    int pval_q[$];

    input_conditioner #(
        .DEBOUNCE_CYCLES  (DEB),
        .COIN_PULSE_CYCLES(PUL),
        .COIN_GAP_CYCLES  (GAP)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .btn_coinl     (btn_coinl),
        .btn_coinr     (btn_coinr),
        .btn_start1    (btn_start1),
        .btn_start2    (btn_start2),
        .btn_test      (btn_test),
        .COINL         (COINL),
        .COINR         (COINR),
        .STARTJMP1     (STARTJMP1),
        .STARTJMP2     (STARTJMP2),
        .SELFTEST      (SELFTEST),
        .coin_pending_l(coin_pending_l),
        .coin_pending_r(coin_pending_r)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic tap_level(input int i, input int hold);
        tap_level = 1'b0;
        foreach (tap_q[k]) begin
            if (i >= tap_q[k] && i < tap_q[k] + hold) tap_level = 1'b1;
        end
    endfunction

    // Slot i is the instant 1 time unit after clock edge i; a tap at slot s
    // is first sampled at edge s+1.
    task automatic run_coin(input int hold, input int nslots, input bit both);
        logic lvl;
        logic exp_low;
        logic prev_coinl;
        int   nfall;
        nfall      = 0;
        prev_coinl = COINL;
        lvl        = tap_level(0, hold);
        btn_coinl  = lvl;
        btn_coinr  = both & lvl;
        for (int i = 1; i <= nslots; i++) begin
            step();
            exp_low = 1'b0;
            foreach (start_q[k]) begin
                if (i >= start_q[k] && i < start_q[k] + PUL) exp_low = 1'b1;
            end
            chk("coinl_level", 32'(COINL), 32'(!exp_low));
            chk("coinr_level", 32'(COINR), 32'(both ? !exp_low : 1'b1));
            foreach (pslot_q[k]) begin
                if (pslot_q[k] == i) begin
                    chk("pending_l", 32'(coin_pending_l), pval_q[k]);
                    if (both) chk("pending_r", 32'(coin_pending_r), pval_q[k]);
                end
            end
            if (prev_coinl && !COINL) nfall++;
            prev_coinl = COINL;
            lvl        = tap_level(i, hold);
            btn_coinl  = lvl;
            btn_coinr  = both & lvl;
        end
        chk("coinl_pulse_count", nfall, start_q.size());
    endtask

    initial begin
        reset_n    = 1'b0;
        btn_coinl  = 1'b0;
        btn_coinr  = 1'b0;
        btn_start1 = 1'b0;
        btn_start2 = 1'b0;
        btn_test   = 1'b0;
        step();
        step();
        chk("reset_outputs", 32'({COINL, COINR, STARTJMP1, STARTJMP2, SELFTEST,
                                  coin_pending_l, coin_pending_r}), 32'h1F0);
        reset_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            chk("idle_outputs", 32'({COINL, COINR, STARTJMP1, STARTJMP2, SELFTEST,
                                     coin_pending_l, coin_pending_r}), 32'h1F0);
        end

        // Short presses of 1..3 clocks never reach the debounced state
        for (int len = 1; len <= 3; len++) begin
            btn_start1 = 1'b1;
            for (int i = 0; i < len; i++) step();
            btn_start1 = 1'b0;
            for (int i = 0; i < 10; i++) begin
                step();
                chk("start1_glitch", 32'(STARTJMP1), 32'd1);
            end
        end

        btn_start1 = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            chk("start1_press", 32'(STARTJMP1), (i < 7) ? 32'd1 : 32'd0);
        end
        btn_start1 = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            chk("start1_release", 32'(STARTJMP1), (i >= 7) ? 32'd1 : 32'd0);
        end

        btn_start2 = 1'b1;
        btn_test   = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            chk("start2_test_press", 32'({STARTJMP2, SELFTEST}), (i < 7) ? 32'd3 : 32'd0);
        end
        btn_start2 = 1'b0;
        btn_test   = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            step();
            chk("start2_test_release", 32'({STARTJMP2, SELFTEST}), (i >= 7) ? 32'd3 : 32'd0);
        end

        // Single tap held 10 clocks: one 6-clock pulse from slot 8
        tap_q = '{0}; start_q = '{8}; pslot_q = '{7, 8}; pval_q = '{1, 0};
        run_coin(10, 40, 1'b0);

        // Held 200 clocks: still a single pulse
        tap_q = '{0}; start_q = '{8}; pslot_q = '{7, 8}; pval_q = '{1, 0};
        run_coin(200, 230, 1'b0);

        // Taps every 8 clocks outpace the 11-clock pulse+gap cadence; the
        // queue fills to 3 and the 12th tap (arriving while full) is dropped.
        tap_q   = '{0, 8, 16, 24, 32, 40, 48, 56, 64, 72, 80, 88};
        start_q = '{8, 19, 30, 41, 52, 63, 74, 85, 96, 107, 118};
        pslot_q = '{7, 8, 39, 41, 62, 63, 71, 74, 79, 94, 95, 96, 118};
        pval_q  = '{1, 0, 2, 1, 2, 2, 3, 2, 3, 3, 3, 2, 0};
        run_coin(4, 140, 1'b0);

        // Both sides tapped on the same clock
        tap_q = '{0}; start_q = '{8}; pslot_q = '{7, 8}; pval_q = '{1, 0};
        run_coin(10, 40, 1'b1);

        // Fifth tap arrives exactly on the GAP->PULSE consume at slot 41
        tap_q   = '{0, 8, 16, 24, 34};
        start_q = '{8, 19, 30, 41, 52};
        pslot_q = '{31, 40, 41, 51, 52};
        pval_q  = '{1, 1, 1, 1, 0};
        run_coin(4, 70, 1'b0);

        // Reset while a pulse is low and one coin is queued
        tap_q = '{0, 8, 16}; start_q = '{8, 19}; pslot_q = '{23}; pval_q = '{1};
        run_coin(4, 23, 1'b0);
        chk("pre_reset_coinl", 32'(COINL), 32'd0);
        reset_n = 1'b0;
        #1;
        chk("async_reset_coinl", 32'(COINL), 32'd1);
        chk("async_reset_pending", 32'(coin_pending_l), 32'd0);
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            chk("post_reset_idle", 32'({COINL, coin_pending_l}), 32'h4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
